// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, controller state encoding and the datapath
// select encodings shared by the controller, ALU control and datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    typedef enum logic [1:0] {
        SRCB_B       = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alusrcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pcsrc_e;

    typedef struct packed {
        logic     pc_write;
        logic     branch;
        logic     iord;
        logic     mem_write;
        logic     ir_write;
        logic     reg_dst;
        logic     mem_to_reg;
        logic     reg_write;
        logic     alu_src_a;
        alusrcb_e alu_src_b;
        aluop_e   alu_op;
        pcsrc_e   pc_src;
        logic     illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive memory-wait cycles and flags the
// WAIT_MAX-th one. Only built when MEM_READY_EN is defined.
`ifdef MEM_READY_EN
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_req,
    output logic expired
);
    localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] count_q, count_d;

    assign expired = wait_req && (count_q == CW'(WAIT_MAX - 1));

    // Count while waiting; restart whenever the wait ends or expires
    always_comb begin
        count_d = '0;
        if (wait_req && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule
`endif

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle MIPS core.
// Define MEM_READY_EN to stall FETCH/MEMRD/MEMWR on MemReady with a timeout.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             Branch,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             IllegalOp,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] InstrCount
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    ctrl_t            ctrl;
    logic             mem_go, hold_state, stall, wait_expired, retire;

    assign hold_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

`ifdef MEM_READY_EN
    logic mem_timeout_q, mem_timeout_d;

    assign mem_go = MemReady;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .wait_req (hold_state & ~MemReady),
        .expired  (wait_expired)
    );

    assign mem_timeout_d = mem_timeout_q | wait_expired;
    assign MemTimeout    = reset ? 1'b0 : mem_timeout_q;
`else
    logic unused_mem_cfg;

    assign mem_go         = 1'b1;
    assign wait_expired   = 1'b0;
    assign MemTimeout     = 1'b0;
    assign unused_mem_cfg = MemReady ^ (WAIT_MAX == 0);
`endif

    assign stall = hold_state & ~mem_go;

    // Next state and retire strobe; a memory stall overrides the normal sequence
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:   state_d = S_FETCH;
        endcase
        if (stall) begin
            state_d = wait_expired ? S_FETCH : state_q;
            retire  = 1'b0;
        end
    end

    assign instr_count_d = instr_count_q + CNT_W'(retire);

    // Moore control word decoded from the state register, forced to 0 in reset
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write  = mem_go;
                ctrl.pc_write  = mem_go;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.illegal_op = ~op_supported(Op);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = mem_go;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JEX: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    assign PCWrite    = ctrl.pc_write;
    assign Branch     = ctrl.branch;
    assign PCEn       = ctrl.pc_write | (ctrl.branch & Zero);
    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign IllegalOp  = ctrl.illegal_op;
    assign InstrCount = reset ? '0 : instr_count_q;

    // State, retired-instruction counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
`ifdef MEM_READY_EN
            mem_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
`ifdef MEM_READY_EN
            mem_timeout_q <= mem_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: instruction-level reference model (opcode plus
// cycle-within-instruction) compared against the controller every cycle,
// with directed literal pins followed by randomized instruction streams.
module tb_multicycle_controller;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MAX = 15;

    // Bit positions of the packed control word used for comparison
    localparam logic [17:0] M_TO    = 18'h00001;
    localparam logic [17:0] M_ILL   = 18'h00002;
    localparam logic [17:0] M_PCSRC = 18'h0000C;
    localparam logic [17:0] M_ALUOP = 18'h00030;
    localparam logic [17:0] M_SRCB  = 18'h000C0;
    localparam logic [17:0] M_SRCA  = 18'h00100;
    localparam logic [17:0] M_RW    = 18'h00200;
    localparam logic [17:0] M_M2R   = 18'h00400;
    localparam logic [17:0] M_RDST  = 18'h00800;
    localparam logic [17:0] M_IRW   = 18'h01000;
    localparam logic [17:0] M_MW    = 18'h02000;
    localparam logic [17:0] M_IORD  = 18'h04000;
    localparam logic [17:0] M_PCEN  = 18'h08000;
    localparam logic [17:0] M_BR    = 18'h10000;
    localparam logic [17:0] M_PCW   = 18'h20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, Zero, MemReady;
    logic [5:0]       Op;
    logic             PCWrite, Branch, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSrc;
    logic             IllegalOp, MemTimeout;
    logic [CNT_W-1:0] InstrCount;

    multicycle_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .Branch(Branch), .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .InstrCount(InstrCount)
    );

    // Reference model state: cycle index inside the current instruction
    int unsigned      m_step = 0;
    int unsigned      m_wait = 0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic             m_to   = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] pin_mask = '0;
    logic [17:0] pin_word = '0;
    int          pin_cnt  = -1;
    logic        dir_mr   = 1'b1;

    // Total cycles taken by each supported opcode; 0 marks an unsupported one
    function automatic int unsigned lat(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            6'h04, 6'h02:        return 3;
            default:             return 0;
        endcase
    endfunction

    function automatic logic waits_on_mem(input int unsigned step, input logic [5:0] op);
`ifdef MEM_READY_EN
        return (step == 0) || (step == 3 && (op == 6'h23 || op == 6'h2B));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [17:0] model_word(input int unsigned step, input logic [5:0] op,
                                               input logic z, input logic go, input logic to);
        logic pcw, br, iord, mw, irw, rdst, m2r, rw, srca, ill;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, br, iord, mw, irw, rdst, m2r, rw, srca, ill} = '0;
        srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0;
        if (step == 0) begin
            irw = go; pcw = go; srcb = 2'd1;
        end else if (step == 1) begin
            srcb = 2'd3; ill = (lat(op) == 0);
        end else begin
            case (op)
                6'h23, 6'h2B: begin
                    if (step == 2) begin srca = 1'b1; srcb = 2'd2; end
                    else if (op == 6'h2B) begin iord = 1'b1; mw = go; end
                    else if (step == 3) iord = 1'b1;
                    else begin rw = 1'b1; m2r = 1'b1; end
                end
                6'h00: begin
                    if (step == 2) begin srca = 1'b1; aluop = 2'd2; end
                    else begin rw = 1'b1; rdst = 1'b1; end
                end
                6'h08: begin
                    if (step == 2) begin srca = 1'b1; srcb = 2'd2; end
                    else rw = 1'b1;
                end
                6'h04: begin srca = 1'b1; aluop = 2'd1; br = 1'b1; pcsrc = 2'd1; end
                6'h02: begin pcw = 1'b1; pcsrc = 2'd2; end
                default: ;
            endcase
        end
        return {pcw, br, pcw | (br & z), iord, mw, irw, rdst, m2r, rw, srca, srcb, aluop, pcsrc, ill, to};
    endfunction

    // Instruction-level model: advance the step, retire, stall or time out
    always @(posedge clk) begin
        if (reset) begin
            m_step <= 0; m_wait <= 0; m_cnt <= '0; m_to <= 1'b0;
        end else if (waits_on_mem(m_step, Op) && !MemReady) begin
            if (m_wait == WAIT_MAX - 1) begin
                m_to <= 1'b1; m_step <= 0; m_wait <= 0;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else begin
            m_wait <= 0;
            if (m_step == 1 && lat(Op) == 0) m_step <= 0;
            else if (m_step != 0 && m_step == lat(Op) - 1) begin
                m_step <= 0; m_cnt <= m_cnt + 1'b1;
            end else m_step <= m_step + 1;
        end
    end

    // Compare process: full control word and counter every cycle, plus pins
    initial begin
        logic [17:0]      got, exp_w;
        logic [CNT_W-1:0] exp_cnt;
        logic             go;
        forever begin
            @(negedge clk);
`ifdef MEM_READY_EN
            go = MemReady;
`else
            go = 1'b1;
`endif
            got = {PCWrite, Branch, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, MemTimeout};
            exp_w   = reset ? '0 : model_word(m_step, Op, Zero, go, m_to);
            exp_cnt = reset ? '0 : m_cnt;
            n_checks++;
            if (got !== exp_w) begin
                n_fail++;
                $display("FAIL ctrl_word t=%0t step=%0d op=%h: got %h expected %h", $time, m_step, Op, got, exp_w);
            end
            n_checks++;
            if (InstrCount !== exp_cnt) begin
                n_fail++;
                $display("FAIL instr_count t=%0t: got %0d expected %0d", $time, InstrCount, exp_cnt);
            end
            if (pin_mask != '0) begin
                n_checks++;
                if ((got & pin_mask) !== (pin_word & pin_mask)) begin
                    n_fail++;
                    $display("FAIL pin_word t=%0t: got %h expected %h (mask %h)", $time, got & pin_mask, pin_word & pin_mask, pin_mask);
                end
            end
            if (pin_cnt >= 0) begin
                n_checks++;
                if (InstrCount !== CNT_W'(pin_cnt)) begin
                    n_fail++;
                    $display("FAIL pin_count t=%0t: got %0d expected %0d", $time, InstrCount, pin_cnt);
                end
            end
        end
    end

    // One directed cycle: drive inputs and literal pins, let it be checked, clock it
    task automatic st(input logic rst, input logic [5:0] op, input logic z,
                      input logic [17:0] mask, input logic [17:0] word, input int cnt);
        reset = rst; Op = op; Zero = z; MemReady = dir_mr;
        pin_mask = mask; pin_word = word; pin_cnt = cnt;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Op = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk);
        #1;
        // Reset: everything zero
        st(1'b1, 6'h00, 1'b0, '1, '0, 0);
        // R-type
        st(1'b0, 6'h00, 1'b0, M_IRW | M_PCW | M_SRCB | M_PCSRC, M_IRW | M_PCW | 18'h00040, 0);
        st(1'b0, 6'h00, 1'b0, M_SRCB | M_ILL, 18'h000C0, 0);
        st(1'b0, 6'h00, 1'b0, M_SRCA | M_SRCB | M_ALUOP, M_SRCA | 18'h00020, 0);
        st(1'b0, 6'h00, 1'b0, M_RW | M_RDST, M_RW | M_RDST, 0);
        // lw
        st(1'b0, 6'h23, 1'b0, M_IRW, M_IRW, 1);
        st(1'b0, 6'h23, 1'b0, '0, '0, 1);
        st(1'b0, 6'h23, 1'b0, M_SRCA | M_SRCB, M_SRCA | 18'h00080, 1);
        st(1'b0, 6'h23, 1'b0, M_IORD | M_MW | M_RW, M_IORD, 1);
        st(1'b0, 6'h23, 1'b0, M_RW | M_M2R | M_RDST, M_RW | M_M2R, 1);
        // sw: MemWrite only in the last cycle
        st(1'b0, 6'h2B, 1'b0, M_MW, '0, 2);
        st(1'b0, 6'h2B, 1'b0, M_MW, '0, 2);
        st(1'b0, 6'h2B, 1'b0, M_MW, '0, 2);
        st(1'b0, 6'h2B, 1'b0, M_MW | M_IORD | M_RW, M_MW | M_IORD, 2);
        // beq taken then not taken
        st(1'b0, 6'h04, 1'b1, '0, '0, 3);
        st(1'b0, 6'h04, 1'b1, '0, '0, 3);
        st(1'b0, 6'h04, 1'b1, M_PCEN | M_PCSRC | M_BR, M_PCEN | M_BR | 18'h00004, 3);
        st(1'b0, 6'h04, 1'b0, '0, '0, 4);
        st(1'b0, 6'h04, 1'b0, '0, '0, 4);
        st(1'b0, 6'h04, 1'b0, M_PCEN | M_BR, M_BR, 4);
        // Unsupported opcode
        st(1'b0, 6'h3F, 1'b0, '0, '0, 5);
        st(1'b0, 6'h3F, 1'b0, M_ILL, M_ILL, 5);
        // lw aborted by reset in MEMRD
        st(1'b0, 6'h23, 1'b0, M_IRW | M_ILL, M_IRW, 5);
        st(1'b0, 6'h23, 1'b0, '0, '0, 5);
        st(1'b0, 6'h23, 1'b0, '0, '0, 5);
        st(1'b1, 6'h23, 1'b0, '1, '0, 0);
        st(1'b0, 6'h00, 1'b0, M_IRW | M_RW, M_IRW, 0);
`ifdef MEM_READY_EN
        st(1'b0, 6'h00, 1'b0, '0, '0, -1);
        st(1'b0, 6'h00, 1'b0, '0, '0, -1);
        st(1'b0, 6'h00, 1'b0, '0, '0, -1);
        st(1'b0, 6'h23, 1'b0, '0, '0, 1);
        st(1'b0, 6'h23, 1'b0, '0, '0, -1);
        st(1'b0, 6'h23, 1'b0, '0, '0, -1);
        dir_mr = 1'b0;
        repeat (3) st(1'b0, 6'h23, 1'b0, M_IORD | M_RW, M_IORD, 1);
        dir_mr = 1'b1;
        st(1'b0, 6'h23, 1'b0, M_IORD | M_RW, M_IORD, 1);
        st(1'b0, 6'h23, 1'b0, M_RW | M_M2R, M_RW | M_M2R, 1);
        dir_mr = 1'b0;
        repeat (WAIT_MAX) st(1'b0, 6'h00, 1'b0, M_IRW | M_PCW | M_TO, '0, 2);
        dir_mr = 1'b1;
        st(1'b0, 6'h00, 1'b0, M_TO | M_IRW, M_TO | M_IRW, 2);
`endif
        // Randomized instruction stream; Op changes only during FETCH
        pin_mask = '0; pin_cnt = -1;
        for (int i = 0; i < 3000; i++) begin
            if (m_step == 0) begin
                case ($urandom_range(0, 6))
                    0: Op = 6'h00;
                    1: Op = 6'h23;
                    2: Op = 6'h2B;
                    3: Op = 6'h04;
                    4: Op = 6'h08;
                    5: Op = 6'h02;
                    default: Op = 6'($urandom_range(0, 63));
                endcase
            end
            Zero     = 1'($urandom_range(0, 1));
            MemReady = ($urandom_range(0, 7) != 0);
            reset    = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
